axi_stream_fifo: RTL

Synchronous first-word-fall-through FIFO for AXI4-Stream, carrying TDATA, TSTRB, TKEEP, TLAST and TUSER between an upstream master and a downstream slave on one clock. Its master port feeds the AXI-Stream slave property set directly, so it must meet every handshake and stability rule that monitor checks. It also reports word occupancy and complete-packet occupancy for upstream flow control.

---
 rtl/axi_stream_fifo.sv | 91 +++++++++
 1 files changed

// File: rtl/axi_stream_fifo.sv
// First-word-fall-through AXI4-Stream FIFO on a single clock.
// Reports stored words (level) and stored TLAST beats (pkt_count) for upstream flow control.
module axi_stream_fifo #(
   parameter int byte_width = 4,
   parameter int user_width = 1,
   parameter int depth_log2 = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    s_tvalid,
   output logic                    s_tready,
   input  logic [8*byte_width-1:0] s_tdata,
   input  logic [byte_width-1:0]   s_tstrb,
   input  logic [byte_width-1:0]   s_tkeep,
   input  logic                    s_tlast,
   input  logic [user_width-1:0]   s_tuser,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic [8*byte_width-1:0] m_tdata,
   output logic [byte_width-1:0]   m_tstrb,
   output logic [byte_width-1:0]   m_tkeep,
   output logic                    m_tlast,
   output logic [user_width-1:0]   m_tuser,
   output logic [depth_log2:0]     level,
   output logic [depth_log2:0]     pkt_count
);

   localparam int data_width  = 8*byte_width;
   localparam int depth       = 1 << depth_log2;
   localparam int entry_width = data_width + 2*byte_width + 1 + user_width;

   typedef logic [depth_log2:0] ptr_t;

   logic [entry_width-1:0] mem [depth];
   logic [entry_width-1:0] head;

   ptr_t wr_ptr;
   ptr_t rd_ptr;
   ptr_t wr_ptr_next;
   ptr_t rd_ptr_next;
   logic push;
   logic pop;
   logic full_next;

   assign push = s_tvalid && s_tready;
   assign pop  = m_tvalid && m_tready;

   // Derived only from registered pointers, so no input reaches m_tvalid combinationally.
   assign m_tvalid = (wr_ptr != rd_ptr);

   always_comb begin
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      if (push) wr_ptr_next = wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr_next = rd_ptr + ptr_t'(1);
      full_next = (wr_ptr_next[depth_log2-1:0] == rd_ptr_next[depth_log2-1:0]) &&
                  (wr_ptr_next[depth_log2] != rd_ptr_next[depth_log2]);
   end

   // Storage is not reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[depth_log2-1:0]] <= {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tuser};
   end

   assign head = mem[rd_ptr[depth_log2-1:0]];
   assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tuser} = head;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         s_tready  <= 1'b0;
         level     <= '0;
         pkt_count <= '0;
      end else begin
         wr_ptr   <= wr_ptr_next;
         rd_ptr   <= rd_ptr_next;
         s_tready <= !full_next;

         if (push && !pop)      level <= level + ptr_t'(1);
         else if (pop && !push) level <= level - ptr_t'(1);

         case ({push && s_tlast, pop && m_tlast})
            2'b10:   pkt_count <= pkt_count + ptr_t'(1);
            2'b01:   pkt_count <= pkt_count - ptr_t'(1);
            default: pkt_count <= pkt_count;
         endcase
      end
   end

endmodule
